mem_arbiter: RTL and testbench

Two-port arbiter that shares the SoC's single-ported synchronous RAM between the rv32i core's instruction-fetch port and its load/store port. It sits inside soc_t between the core and the block RAM loaded from the ROM image. It serialises accesses with a small state machine and returns read data and a one-cycle acknowledge to whichever port was granted.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between the fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN for round-robin contention instead of data-first priority.
module mem_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  state_t state;
  logic   gnt_d;
  logic   rd_op;
  logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_comb begin
    pick_d = d_req && (!i_req || !last_d);
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // mem_* double as the issue registers: loaded in IDLE, driven during ISSUE
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      rd_op     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b1;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            gnt_d    <= pick_d;
            rd_op    <= !(pick_d && d_we);
            mem_en   <= 1'b1;
            mem_addr <= pick_d ? d_addr : i_addr;
            mem_we   <= (pick_d && d_we) ? d_wmask : 4'b0000;
            if (pick_d) begin
              mem_wdata <= d_wdata;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_d   <= pick_d;
`endif
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (rd_op) begin
            if (gnt_d) begin
              d_rdata <= mem_rdata;
            end else begin
              i_rdata <= mem_rdata;
            end
          end
          i_ack <= !gnt_d;
          d_ack <= gnt_d;
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port RAM.
// Expected read data is queued per port at issue and checked on each ack.
module tb_mem_arbiter;

  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_wmask;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int i_acks = 0;
  int d_acks = 0;
  int en_cnt = 0;
  int we_cnt = 0;
  logic [3:0] last_we = '0;

  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] ram [0:(1<<AW)-1];

  mem_arbiter #(.ADDR_W(AW)) dut (
    .CLK(CLK), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_wmask(d_wmask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mem_en) en_cnt++;
    if (mem_we != 4'b0000) begin
      we_cnt++;
      last_we = mem_we;
    end
    if (resetn && i_ack && d_ack) chk("ack_overlap", 32'd1, 32'd0);
    if (resetn && i_ack) begin
      i_acks++;
      if (i_q.size() == 0) chk("i_ack_unexpected", 32'd1, 32'd0);
      else chk("i_rdata", i_rdata, i_q.pop_front());
    end
    if (resetn && d_ack) begin
      d_acks++;
      if (d_q.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
      else chk("d_rdata", d_rdata, d_q.pop_front());
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
    chk({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {28'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic access(input bit dp, input bit we, input logic [3:0] mask,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string tag);
    int lat;
    bit got;
    @(negedge CLK);
    if (dp) begin
      d_req = 1'b1; d_we = we; d_wmask = mask;
      d_addr = addr; d_wdata = wdata;
      d_q.push_back(exp);
    end else begin
      i_req = 1'b1; i_addr = addr;
      i_q.push_back(exp);
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
      if (dp ? d_ack : i_ack) got = 1'b1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk({tag, "_latency"}, lat, 32'd3);
    @(posedge CLK); #1;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  int w0, a0, e0;
  bit win_d;
  int lat;

  initial begin
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_wmask = '0;
    d_addr = '0; d_wdata = '0;
    resetn = 1'b0;
    for (int k = 0; k < (1 << AW); k++) ram[k] = 32'h0;
    ram[5] = 32'hDEADBEEF;
    ram[3] = 32'hAABBCCDD;
    ram[7] = 32'h12345678;
    ram[8] = 32'hCAFEF00D;
    ram[12'hFFF] = 32'h0BADF00D;
    #1;
    check_reset("por");
    repeat (2) @(negedge CLK);
    resetn = 1'b1;

    access(0, 0, 4'h0, 12'd5, 32'h0, 32'hDEADBEEF, "fetch5");

    w0 = we_cnt;
    access(1, 1, 4'b0101, 12'd3, 32'h11223344, 32'h0, "store3");
    chk("store3_we_cycles", w0 == we_cnt - 1, 32'd1);
    chk("store3_we_mask", {28'd0, last_we}, 32'h5);
    access(1, 0, 4'h0, 12'd3, 32'h0, 32'hAA22CC44, "load3");

    w0 = we_cnt;
    access(1, 1, 4'b0000, 12'd5, 32'hFFFFFFFF, 32'hAA22CC44, "store0");
    chk("store0_we_cycles", we_cnt - w0, 32'd0);
    access(0, 0, 4'h0, 12'd5, 32'h0, 32'hDEADBEEF, "fetch5b");
    access(0, 0, 4'h0, 12'hFFF, 32'h0, 32'h0BADF00D, "fetch_top");

    e0 = en_cnt;
    a0 = i_acks;
    @(negedge CLK);
    i_req = 1'b1; i_addr = 12'd3;
    i_q.push_back(32'hAA22CC44);
    @(negedge CLK);
    i_req = 1'b0;
    repeat (8) @(negedge CLK);
    chk("withdraw_acks", i_acks - a0, 32'd1);
    chk("withdraw_accesses", en_cnt - e0, 32'd1);

    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF;
    d_addr = 12'd8; d_wdata = 32'h0;
    @(posedge CLK); #2;
    resetn = 1'b0;
    #1;
    check_reset("rst_issue");
    d_req = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    chk("rst_issue_ram8", ram[8], 32'hCAFEF00D);

    a0 = d_acks;
    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF;
    d_addr = 12'd7; d_wdata = 32'h55;
    @(posedge CLK);
    @(posedge CLK); #2;
    resetn = 1'b0;
    #1;
    check_reset("rst_wait");
    d_req = 1'b0;
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_wait_no_ack", d_acks - a0, 32'd0);

    access(0, 0, 4'h0, 12'd5, 32'h0, 32'hDEADBEEF, "fresh_fetch");

    @(negedge CLK);
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = (r == 1);
`else
      win_d = 1'b1;
`endif
      @(negedge CLK);
      i_req = 1'b1; i_addr = 12'd5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'd3;
      if (win_d) d_q.push_back(32'hAA22CC44);
      else i_q.push_back(32'hDEADBEEF);
      lat = 0;
      while (!(i_ack || d_ack) && lat < 8) begin
        @(posedge CLK); #1;
        lat++;
      end
      i_req = 1'b0;
      d_req = 1'b0;
      chk("contend_latency", lat, 32'd3);
      chk("contend_winner", {31'd0, d_ack}, {31'd0, win_d});
      @(posedge CLK); #1;
    end

    repeat (6) @(negedge CLK);
    chk("i_q_drained", i_q.size(), 32'd0);
    chk("d_q_drained", d_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
